// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types and constants for the writeback controller.
// Register-file bus widths live here so the top and the buffer agree.
package reg_wb_ctrl_pkg;

  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  typedef logic [4:0]  reg_addr_t;  // RegAddrBus
  typedef logic [31:0] reg_data_t;  // RegBus

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_entry_t;

  // Register 0 is hardwired, so it never shows up as pending.
  function automatic logic [31:0] addr_onehot(input reg_addr_t addr);
    return (32'h1 << addr) & ~32'h1;
  endfunction

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Circular buffer of long-latency results with kill-by-address.
// Live entries are re-packed from the read pointer every cycle, so a kill frees its slot at once.
module wb_fifo
  import reg_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  reg_addr_t                push_addr,
  input  reg_data_t                push_data,
  input  logic                     pop,
  input  logic                     kill,
  input  reg_addr_t                kill_addr,
  output reg_addr_t                head_addr,
  output reg_data_t                head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q   [DEPTH];
  wb_entry_t        mem_d   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] src;
  logic [PTR_W-1:0] dst;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] live;
  logic [31:0]      pending_q;
  logic [31:0]      pending_d;
  logic             keep;

  assign head_addr = mem_q[rd_ptr_q].addr;
  assign head_data = mem_q[rd_ptr_q].data;
  assign count     = count_q;
  assign pending   = pending_q;

  // Survivors (not popped, not killed) are copied in order behind the new read pointer, then the push lands after them.
  always_comb begin
    mem_d     = mem_q;
    valid_d   = '0;
    live      = '0;
    src       = '0;
    dst       = '0;
    keep      = 1'b0;
    pending_d = '0;
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      src  = rd_ptr_q + PTR_W'(i);
      keep = (i < int'(count_q)) && valid_q[src] && !(pop && i == 0) &&
             !(kill && mem_q[src].addr == kill_addr);
      if (keep) begin
        dst          = rd_ptr_d + live[PTR_W-1:0];
        mem_d[dst]   = mem_q[src];
        valid_d[dst] = 1'b1;
        live         = live + 1'b1;
      end
    end
    wr_ptr = rd_ptr_d + live[PTR_W-1:0];
    if (push && push_addr != '0 && !(kill && push_addr == kill_addr) &&
        live != CNT_W'(DEPTH)) begin
      mem_d[wr_ptr]   = '{addr: push_addr, data: push_data};
      valid_d[wr_ptr] = 1'b1;
      live            = live + 1'b1;
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (valid_d[j]) pending_d = pending_d | addr_onehot(mem_d[j].addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      valid_q   <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      valid_q   <= valid_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= live;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Register-file write-port arbiter: MEM-stage results win, buffered
// long-latency results fill the idle slots.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_wd_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        lu_valid_i,
  input  logic [4:0]  lu_wd_i,
  input  logic [31:0] lu_wdata_i,
  output logic        lu_ready_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_w_addr_o,
  output logic [31:0] reg_w_data_o,
  output logic [31:0] pending_o,
  output logic        wb_stall_req_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count;
  logic             full;
  logic             pipe_valid;
  logic             push;
  logic             pop;
  reg_addr_t        head_addr;
  reg_data_t        head_data;

  assign pipe_valid     = !stall_i && (mem_wreg_i == WriteEnable) && (mem_wd_i != '0);
  assign full           = (count == CNT_W'(DEPTH));
  // Gated by rst so ready reads 0 while held in reset and rises as soon as reset lets go.
  assign lu_ready_o     = rst && !full;
  assign wb_stall_req_o = full;
  assign push           = lu_valid_i && lu_ready_o;
  assign pop            = !pipe_valid && (count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (lu_wd_i),
    .push_data (lu_wdata_i),
    .pop       (pop),
    .kill      (pipe_valid),
    .kill_addr (mem_wd_i),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .pending   (pending_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_we_o     <= WriteDisable;
      reg_w_addr_o <= '0;
      reg_w_data_o <= ZeroWord;
    end else if (pipe_valid) begin
      reg_we_o     <= WriteEnable;
      reg_w_addr_o <= mem_wd_i;
      reg_w_data_o <= mem_wdata_i;
    end else if (pop) begin
      reg_we_o     <= WriteEnable;
      reg_w_addr_o <= head_addr;
      reg_w_data_o <= head_data;
    end else begin
      reg_we_o     <= WriteDisable;
      reg_w_addr_o <= '0;
      reg_w_data_o <= ZeroWord;
    end
  end

endmodule
